// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// Single outstanding request: req/gnt for the address phase, rvalid/rdata for load data.
interface load_store_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_be,
        output dmem_wdata,
        input  dmem_gnt,
        input  dmem_rvalid,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_be,
        input  dmem_wdata,
        output dmem_gnt,
        output dmem_rvalid,
        output dmem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte-lane alignment, single-outstanding data-memory bus,
// sign/zero-extended load write-back and one-cycle error reporting.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a new op; error ops are completed from here
// ST_REQ  | dmem_req high, bus outputs frozen until dmem_gnt
// ST_WAIT | load granted, waiting for dmem_rvalid
module load_store_unit (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    is_store,
    input  logic [2:0]              funct3,
    input  logic [31:0]             ALU_result,
    input  logic [31:0]             store_data,
    input  logic [4:0]              rd_addr,
    load_store_unit_if.master       dmem,
    output logic                    wb_valid,
    output logic [4:0]              wb_rd,
    output logic [31:0]             wb_data,
    output logic                    done,
    output logic                    err,
    output logic [31:0]             err_addr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic        ready_q;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;

    logic        accept;
    logic        op_err;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic        done_d;
    logic        err_d;
    logic        wb_d;
    logic [31:0] rdata_shifted;
    logic [31:0] load_ext;

    // Lane decode and legality check on the raw (not yet captured) op.
    always_comb begin
        op_err  = 1'b0;
        be_d    = 4'b0000;
        wdata_d = store_data;
        case (funct3)
            3'b000: begin
                be_d    = 4'b0001 << ALU_result[1:0];
                wdata_d = {4{store_data[7:0]}};
            end
            3'b100: begin
                be_d    = 4'b0001 << ALU_result[1:0];
                wdata_d = {4{store_data[7:0]}};
                op_err  = is_store;
            end
            3'b001: begin
                be_d    = ALU_result[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{store_data[15:0]}};
                op_err  = ALU_result[0];
            end
            3'b101: begin
                be_d    = ALU_result[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{store_data[15:0]}};
                op_err  = ALU_result[0] | is_store;
            end
            3'b010: begin
                be_d    = 4'b1111;
                wdata_d = store_data;
                op_err  = (ALU_result[1:0] != 2'b00);
            end
            default: begin
                op_err  = 1'b1;
            end
        endcase
    end

    // ready_q keeps req_ready low while reset is held and for the release edge.
    assign req_ready = (state_q == ST_IDLE) && ready_q;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wb_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op_err) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (dmem.dmem_gnt) begin
                    if (is_store_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (dmem.dmem_rvalid) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    wb_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rdata_shifted = dmem.dmem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = rdata_shifted;
        case (funct3_q)
            3'b000:  load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b100:  load_ext = {24'h000000, rdata_shifted[7:0]};
            3'b001:  load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b101:  load_ext = {16'h0000, rdata_shifted[15:0]};
            default: load_ext = rdata_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q    <= 1'b0;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= 32'h0;
            be_q       <= 4'b0000;
            wdata_q    <= 32'h0;
            rd_q       <= 5'd0;
        end else begin
            ready_q <= 1'b1;
            if (accept && !op_err) begin
                is_store_q <= is_store;
                funct3_q   <= funct3;
                addr_q     <= ALU_result;
                be_q       <= be_d;
                wdata_q    <= wdata_d;
                rd_q       <= rd_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done     <= 1'b0;
            err      <= 1'b0;
            err_addr <= 32'h0;
            wb_valid <= 1'b0;
            wb_rd    <= 5'd0;
            wb_data  <= 32'h0;
        end else begin
            done     <= done_d;
            err      <= err_d;
            wb_valid <= wb_d;
            if (err_d) begin
                err_addr <= ALU_result;
            end
            if (wb_d) begin
                wb_rd   <= rd_q;
                wb_data <= load_ext;
            end
        end
    end

    // Bus outputs come straight from captured registers, so they cannot move during a stall.
    assign dmem.dmem_req   = (state_q == ST_REQ);
    assign dmem.dmem_we    = (state_q == ST_REQ) && is_store_q;
    assign dmem.dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;

endmodule
